// File: rtl/logic_gate_pipe.sv
// Two-stage valid/ready pipeline applying a selectable bitwise gate to a and b.
// Stage 1 captures the operands and the operation; stage 2 holds the registered result.
module logic_gate_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             out_all1,
   output logic             out_zero,
   output logic [CNT_W-1:0] count
);

   typedef enum logic [2:0] {
      OP_AND   = 3'd0,
      OP_OR    = 3'd1,
      OP_XOR   = 3'd2,
      OP_NAND  = 3'd3,
      OP_NOR   = 3'd4,
      OP_XNOR  = 3'd5,
      OP_ANDN  = 3'd6,
      OP_PASSA = 3'd7
   } op_e;

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   op_e              s1_op;
   logic             s2_valid;
   logic [WIDTH-1:0] res;
   logic             out_fire;
   logic             in_fire;
   logic             s2_load;

   assign out_fire  = s2_valid && out_ready;
   assign s2_load   = s1_valid && (!s2_valid || out_fire);
   // Ready looks ahead through stage 1 so a full pipe still streams one per cycle.
   assign in_ready  = !rst && (!s1_valid || s2_load);
   assign in_fire   = in_valid && in_ready;
   assign out_valid = s2_valid;

   always_comb begin
      res = '0;
      unique case (s1_op)
         OP_AND:   res = s1_a & s1_b;
         OP_OR:    res = s1_a | s1_b;
         OP_XOR:   res = s1_a ^ s1_b;
         OP_NAND:  res = ~(s1_a & s1_b);
         OP_NOR:   res = ~(s1_a | s1_b);
         OP_XNOR:  res = ~(s1_a ^ s1_b);
         OP_ANDN:  res = s1_a & ~s1_b;
         OP_PASSA: res = s1_a;
         default:  res = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= OP_AND;
      end else begin
         if (in_fire) begin
            s1_valid <= 1'b1;
            s1_a     <= a;
            s1_b     <= b;
            s1_op    <= op_e'(op);
         end else if (s2_load) begin
            s1_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         out      <= '0;
         out_all1 <= 1'b0;
         out_zero <= 1'b0;
      end else begin
         if (s2_load) begin
            s2_valid <= 1'b1;
            out      <= res;
            out_all1 <= &res;
            out_zero <= (res == '0);
         end else if (out_fire) begin
            s2_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (out_fire && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule
